datapath: RTL

Execution datapath for the 8-bit accumulator CPU. It sits directly downstream of `control` and consumes its six strobes (`ir_load`, `pc_load`, `inmux`, `a_load`, `jnz_mux`, `halt`). It returns `ir[7:0]` and `an_0` to `control`. It holds PC, IR and accumulator A, plus a 32x8 program memory that is loaded over a side port while the CPU is held in reset.

---
 rtl/datapath.sv | 67 ++++++
 1 files changed

// File: rtl/datapath.sv
// datapath: PC, IR, accumulator and program memory
// for the 8-bit accumulator CPU, driven by control strobes.
module datapath #(
  parameter int AW = 5,
  parameter int DW = 8
) (
  input  logic          clock,
  input  logic          clear,
  input  logic          ir_load,
  input  logic          pc_load,
  input  logic          inmux,
  input  logic          a_load,
  input  logic          jnz_mux,
  input  logic          halt,
  input  logic [DW-1:0] in_data,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [DW-1:0] prog_data,
  output logic [DW-1:0] ir,
  output logic          an_0,
  output logic [DW-1:0] a_out,
  output logic [AW-1:0] pc_out,
  output logic          halted
);

  logic [DW-1:0] mem [2**AW];
  logic [AW-1:0] pc;
  logic [DW-1:0] acc;
  logic [AW-1:0] pc_next;
  logic [DW-1:0] acc_next;

  // Loader port is free-running: usable during clear and halt.
  always_ff @(posedge clock) begin
    if (prog_we)
      mem[prog_addr] <= prog_data;
  end

  always_comb begin
    pc_next  = jnz_mux ? ir[AW-1:0] : pc + 1'b1;
    acc_next = inmux ? in_data : acc - 1'b1;
  end

  // Fetch reads the pre-edge word, so a colliding write is not seen.
  always_ff @(posedge clock) begin
    if (clear) begin
      pc     <= '0;
      ir     <= '0;
      acc    <= '0;
      halted <= 1'b0;
    end else begin
      halted <= halt;
      if (!halt) begin
        if (ir_load)
          ir <= mem[pc];
        if (pc_load)
          pc <= pc_next;
        if (a_load)
          acc <= acc_next;
      end
    end
  end

  assign an_0   = |acc;
  assign a_out  = acc;
  assign pc_out = pc;

endmodule
